// File: rtl/tx_packet_framer_if.sv
// Byte-source / modulator side signals of the transmit packet framer.
// The master drives configuration, start, bit strobe and payload bytes;
// the slave (the framer) returns the serial bit and frame status.
interface tx_packet_framer_if #(
    parameter int MAX_PREAMBLE_WIDTH = 8
);
    logic [MAX_PREAMBLE_WIDTH-1:0] TX_PREAMBLE_LEN;
    logic [7:0]                    TX_PAYLOAD_LEN;
    logic                          start;
    logic                          bit_en;
    logic [7:0]                    data_in;
    logic                          data_valid;
    logic                          data_ready;
    logic                          BPSK;
    logic                          tx_active;
    logic                          frame_done;
    logic                          underrun;

    modport master (
        output TX_PREAMBLE_LEN, TX_PAYLOAD_LEN, start, bit_en, data_in, data_valid,
        input  data_ready, BPSK, tx_active, frame_done, underrun
    );

    modport slave (
        input  TX_PREAMBLE_LEN, TX_PAYLOAD_LEN, start, bit_en, data_in, data_valid,
        output data_ready, BPSK, tx_active, frame_done, underrun
    );
endinterface

// File: rtl/tx_packet_framer.sv
// Transmit packet framer: one frame per accepted start pulse, one bit per
// bit_en strobe. Frame = alternating preamble, sync word, payload length
// byte, payload bytes, all MSB first. Payload bytes come through a one-byte
// holding buffer; a byte missing at its boundary is sent as 8'h00 and flags
// a sticky underrun.
module tx_packet_framer #(
    parameter int                    MAX_PREAMBLE_WIDTH = 8,
    parameter int                    SYNC_WIDTH         = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD          = 16'hF0C3
) (
    input  logic               clk,
    input  logic               rst,
    tx_packet_framer_if.slave  bus
);

    // Bit counter must hold a full preamble count and a sync-word index.
    localparam int SYNC_CNT_W = $clog2(SYNC_WIDTH) + 1;
    localparam int CNT_W      = (MAX_PREAMBLE_WIDTH > SYNC_CNT_W) ? MAX_PREAMBLE_WIDTH : SYNC_CNT_W;
    // Shift register is left aligned and must hold either the sync word or a byte.
    localparam int SR_W       = (SYNC_WIDTH > 8) ? SYNC_WIDTH : 8;

    // TAIL waits for the strobe that ends the last bit's period.
    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        LENGTH,
        PAYLOAD,
        TAIL
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              bit_cnt;
    logic [7:0]                    byte_cnt;
    logic [7:0]                    fetch_cnt;
    logic [MAX_PREAMBLE_WIDTH-1:0] pre_len;
    logic [7:0]                    pay_len;
    logic [SR_W-1:0]               shreg;
    logic [7:0]                    buf_q;
    logic                          buf_valid;
    logic                          bpsk_q;
    logic                          active_q;
    logic                          done_q;
    logic                          underrun_q;

    logic                          data_ready_int;
    logic                          fetch;
    logic [CNT_W-1:0]              bit_cnt_inc;
    logic                          last_pre;
    logic                          last_sync;
    logic                          last8;
    logic [7:0]                    load_byte;

    // Handshake and bit-position decodes derived from registered state only.
    always_comb begin
        data_ready_int = active_q & ~buf_valid & (fetch_cnt < pay_len);
        fetch          = bus.data_valid & data_ready_int;
        bit_cnt_inc    = bit_cnt + CNT_W'(1);
        last_pre       = (bit_cnt_inc == CNT_W'(pre_len));
        last_sync      = (bit_cnt == CNT_W'(SYNC_WIDTH - 1));
        last8          = (bit_cnt == CNT_W'(7));
        load_byte      = buf_valid ? buf_q : 8'h00;
    end

    // Frame sequencer, byte buffer and registered outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the holding buffer is a single register, so it is cleared
            // with everything else; only buf_valid actually matters.
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            fetch_cnt  <= '0;
            pre_len    <= '0;
            pay_len    <= '0;
            shreg      <= '0;
            buf_q      <= '0;
            buf_valid  <= 1'b0;
            bpsk_q     <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (fetch) begin
                buf_q     <= bus.data_in;
                buf_valid <= 1'b1;
                fetch_cnt <= fetch_cnt + 8'd1;
            end

            if (state == IDLE) begin
                // bit_en in the start cycle is deliberately ignored.
                if (bus.start) begin
                    pre_len    <= bus.TX_PREAMBLE_LEN;
                    pay_len    <= bus.TX_PAYLOAD_LEN;
                    active_q   <= 1'b1;
                    underrun_q <= 1'b0;
                    bit_cnt    <= '0;
                    byte_cnt   <= '0;
                    fetch_cnt  <= '0;
                    buf_valid  <= 1'b0;
                    shreg      <= SR_W'(SYNC_WORD) << (SR_W - SYNC_WIDTH);
                    state      <= (bus.TX_PREAMBLE_LEN == '0) ? SYNC : PREAMBLE;
                end
            end else if (bus.bit_en) begin
                case (state)
                    PREAMBLE: begin
                        bpsk_q <= bit_cnt[0];
                        if (last_pre) begin
                            bit_cnt <= '0;
                            state   <= SYNC;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                        end
                    end
                    SYNC: begin
                        bpsk_q <= shreg[SR_W-1];
                        if (last_sync) begin
                            bit_cnt <= '0;
                            shreg   <= SR_W'(pay_len) << (SR_W - 8);
                            state   <= LENGTH;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                            shreg   <= shreg << 1;
                        end
                    end
                    LENGTH: begin
                        bpsk_q <= shreg[SR_W-1];
                        shreg  <= shreg << 1;
                        if (last8) begin
                            bit_cnt <= '0;
                            state   <= (pay_len == 8'd0) ? TAIL : PAYLOAD;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                        end
                    end
                    PAYLOAD: begin
                        if (bit_cnt == '0) begin
                            // Byte boundary: take the buffered byte (or zero on underrun).
                            bpsk_q   <= load_byte[7];
                            shreg    <= SR_W'(load_byte) << (SR_W - 7);
                            byte_cnt <= byte_cnt + 8'd1;
                            if (!buf_valid) underrun_q <= 1'b1;
                            if (!fetch) buf_valid <= 1'b0;
                        end else begin
                            bpsk_q <= shreg[SR_W-1];
                            shreg  <= shreg << 1;
                        end
                        if (last8) begin
                            bit_cnt <= '0;
                            if (byte_cnt == pay_len) state <= TAIL;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                        end
                    end
                    TAIL: begin
                        bpsk_q   <= 1'b0;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_ready = data_ready_int;
    assign bus.BPSK       = bpsk_q;
    assign bus.tx_active  = active_q;
    assign bus.frame_done = done_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// Self-checking bench for tx_packet_framer. Each frame's expected bit stream
// is built directly from the frame format (preamble, sync, length, payload)
// and compared bit by bit with what BPSK shows after every bit_en strobe.
module tb_tx_packet_framer;

    localparam logic [15:0] SYNC = 16'hF0C3;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] src_bytes[$];

    always #5 clk = ~clk;

    tx_packet_framer_if #(.MAX_PREAMBLE_WIDTH(8)) bus ();

    tx_packet_framer #(
        .MAX_PREAMBLE_WIDTH (8),
        .SYNC_WIDTH         (16),
        .SYNC_WORD          (16'hF0C3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_bytes(input int n);
        src_bytes.delete();
        for (int i = 0; i < n; i++) src_bytes.push_back(8'($urandom));
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.bit_en     = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    // Runs one frame starting at the current point (just after a clock edge).
    // withhold: payload index never offered (-1 for none); restart_at: strobe
    // count at which start is pulsed again; abort_at: strobe count at which
    // rst is applied and the frame abandoned (0 for none).
    task automatic run_frame(input int pre, input int pay, input int period,
                             input int withhold, input int restart_at, input int abort_at);
        bit         exp_q[$];
        bit         got_q[$];
        logic [7:0] lb;
        logic [7:0] b;
        logic       last_bpsk;
        logic       prev_en;
        bit         exp_unr;
        int         strobes, done_at, fires, ready_hi, c, next_idx, budget, n;

        // Expected stream straight from the frame format.
        for (int i = 0; i < pre; i++) exp_q.push_back(bit'(i % 2));
        for (int i = 15; i >= 0; i--) exp_q.push_back(SYNC[i]);
        lb = 8'(pay);
        for (int i = 7; i >= 0; i--) exp_q.push_back(lb[i]);
        for (int k = 0; k < pay; k++) begin
            b = (k == withhold) ? 8'h00 : src_bytes[k];
            for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        end
        exp_unr = (withhold >= 0) && (withhold < pay);
        budget  = (exp_q.size() + 2) * period + 20;

        strobes = 0; done_at = 0; fires = 0; ready_hi = 0; c = 0; next_idx = 0;
        last_bpsk = 1'b0;

        bus.start           = 1'b1;
        bus.TX_PREAMBLE_LEN = 8'(pre);
        bus.TX_PAYLOAD_LEN  = 8'(pay);
        bus.bit_en          = 1'b1;
        bus.data_valid      = 1'b0;
        bus.data_in         = 8'h00;
        prev_en             = 1'b1;

        while (done_at == 0 && c < budget) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                check("tx_active_after_start", bus.tx_active, 1);
                check("underrun_cleared_on_start", bus.underrun, 0);
                check("start_strobe_ignored", bus.BPSK, 0);
                check("no_ready_in_start_cycle_result", bus.frame_done, 0);
            end else if (prev_en) begin
                strobes++;
                if (bus.frame_done) begin
                    done_at = strobes;
                    check("end_bpsk_zero", bus.BPSK, 0);
                    check("end_tx_active_low", bus.tx_active, 0);
                end else begin
                    got_q.push_back(bus.BPSK);
                    last_bpsk = bus.BPSK;
                end
            end else begin
                check("bpsk_hold", bus.BPSK, last_bpsk);
                check("frame_done_without_strobe", bus.frame_done, 0);
            end

            if (abort_at > 0 && strobes == abort_at && done_at == 0) begin
                rst = 1'b1;
                idle_inputs();
                @(posedge clk);
                #1;
                check("abort_bpsk", bus.BPSK, 0);
                check("abort_tx_active", bus.tx_active, 0);
                check("abort_data_ready", bus.data_ready, 0);
                check("abort_frame_done", bus.frame_done, 0);
                rst = 1'b0;
                @(posedge clk);
                #1;
                check("abort_no_frame_done_later", bus.frame_done, 0);
                return;
            end

            c++;
            bus.start           = (restart_at > 0 && strobes == restart_at);
            bus.TX_PREAMBLE_LEN = 8'($urandom);
            bus.TX_PAYLOAD_LEN  = 8'($urandom);
            bus.bit_en          = ((c % period) == 0);
            // Give up on the withheld byte once its boundary strobe has passed.
            if (withhold >= 0 && next_idx == withhold && strobes >= pre + 25 + 8 * withhold)
                next_idx++;
            if (next_idx < pay && next_idx != withhold) begin
                bus.data_valid = 1'b1;
                bus.data_in    = src_bytes[next_idx];
            end else begin
                bus.data_valid = 1'b0;
                bus.data_in    = 8'($urandom);
            end
            if (bus.data_ready) ready_hi++;
            if (bus.data_valid && bus.data_ready) begin
                fires++;
                next_idx++;
            end
            prev_en = bus.bit_en;
        end

        idle_inputs();
        check("frame_done_seen", 32'(done_at != 0), 1);
        check("bit_count", got_q.size(), exp_q.size());
        check("done_after_last_bit_period", done_at, exp_q.size() + 1);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("bit%0d", i), got_q[i], exp_q[i]);
        check("underrun", bus.underrun, exp_unr);
        check("bytes_transferred", fires, pay - int'(exp_unr));
        if (pay == 0) check("data_ready_never", ready_hi, 0);
        @(posedge clk);
        #1;
        check("frame_done_one_cycle", bus.frame_done, 0);
        check("idle_data_ready", bus.data_ready, 0);
        check("idle_underrun_sticky", bus.underrun, exp_unr);
    endtask

    initial begin
        int pre, pay, per, wh;

        rst                 = 1'b1;
        bus.TX_PREAMBLE_LEN = 8'd0;
        bus.TX_PAYLOAD_LEN  = 8'd0;
        bus.data_in         = 8'h00;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_bpsk", bus.BPSK, 0);
        check("reset_tx_active", bus.tx_active, 0);
        check("reset_frame_done", bus.frame_done, 0);
        check("reset_underrun", bus.underrun, 0);
        check("reset_data_ready", bus.data_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal frame with known bytes.
        src_bytes = '{8'hA5, 8'h3C};
        run_frame(8, 2, 4, -1, 0, 0);

        // No preamble, empty payload: sync plus zero length only.
        src_bytes.delete();
        run_frame(0, 0, 4, -1, 0, 0);

        // Second byte withheld, then a fresh start clears underrun.
        fill_bytes(3);
        run_frame(6, 3, 4, 1, 0, 0);
        fill_bytes(1);
        run_frame(4, 1, 3, -1, 0, 0);

        // Start re-pulsed mid-sync, then an immediate back-to-back frame.
        src_bytes = '{8'hA5, 8'h3C};
        run_frame(8, 2, 2, -1, 8 + 5, 0);
        run_frame(8, 2, 2, -1, 0, 0);

        // Reset mid-payload, then a complete frame.
        fill_bytes(4);
        run_frame(4, 4, 2, -1, 0, 4 + 24 + 8 + 10);
        run_frame(4, 4, 2, -1, 0, 0);

        // Start and bit_en together, bit_en every clock.
        fill_bytes(2);
        run_frame(5, 2, 1, -1, 0, 0);

        // Maximum lengths: exactly 255 preamble bits and 255 payload bytes.
        fill_bytes(255);
        run_frame(255, 255, 1, -1, 0, 0);

        // Randomized frames.
        for (int t = 0; t < 10; t++) begin
            pre = $urandom_range(0, 20);
            pay = $urandom_range(0, 8);
            per = $urandom_range(1, 5);
            wh  = (pay > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, pay - 1) : -1;
            fill_bytes(pay);
            run_frame(pre, pay, per, wh, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
